barrel_unshifter_seq: RTL and testbench
=======================================

Name: barrel_unshifter_seq

Overview:
- Sequential inverse of the team's 4-bit barrel shifter: takes a shifted word plus the `mode`/`shift_amt` that produced it, and reconstructs the pre-shift word.
- Undoes one bit position per cycle under a valid/ready handshake.
- Flags results where shifted-out bits were lost.
- Sits in the datapath verification/recovery path, downstream of the barrel shifter.

Parameters:
- WIDTH, 4, data word width in bits.
- AMT_W, 2, width of `shift_amt`; must satisfy 2**AMT_W == WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- data_in  input  WIDTH  shifted word to restore.
- shift_amt  input  AMT_W  shift amount originally applied.
- mode  input  3  original shift mode (same encoding as the shifter).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- data_out  output  WIDTH  restored word.
- lossy  output  1  restored word has zero-filled positions whose original value is unknown.
- err  output  1  input inconsistent with the claimed shift (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE; data_out=0, out_valid=0, lossy=0, err=0; in_ready=1 once in IDLE.
- Mode to inverse operation, one position per SHIFT cycle, with lossy condition:
  - 000 LSL: inverse LSR, zero fill; lossy if amt!=0.
  - 001 LSR: inverse LSL, zero fill; lossy if amt!=0.
  - 010 ASL: inverse LSR, zero fill; lossy if amt!=0.
  - 011 ASR: inverse LSL, zero fill; lossy if amt!=0.
  - 100 ROL: inverse ROR; lossy=0.
  - 101 ROR: inverse ROL; lossy=0.
  - 110/111: pass-through, zero iterations; lossy=0.
- FSM IDLE -> SHIFT -> DONE.
  - IDLE: on in_valid && in_ready, latch data_in into the work register, latch mode, load a counter with shift_amt (forced to 0 for 110/111), compute lossy/err. Go to SHIFT if count != 0, else DONE.
  - SHIFT: each cycle apply one inverse step and decrement the counter. When the counter reaches 1, the step completes and the next state is DONE.
  - DONE: out_valid=1; data_out, lossy and err are held stable while !out_ready. On out_ready, go to IDLE and drop out_valid.
  - in_ready is low in SHIFT and DONE; there is no same-cycle accept on DONE exit.
- Latency from the accept edge to out_valid high: amt+1 cycles. Throughput: one request per amt+2 cycles minimum.
- data_out updates only on the DONE entry edge; it holds its last value in IDLE/SHIFT.
- rst_n low mid-SHIFT or mid-DONE aborts the operation, returns to IDLE with reset values, and drops the result.
- in_valid while busy is ignored; the source must hold it.

Optional Feature:
- Macro UNSHIFT_CHECK_EN.
- When defined, err is computed at accept from data_in and amt=n:
  - LSL/ASL: err if the low n bits are not all 0.
  - LSR: err if the top n bits are not all 0.
  - ASR: err if the top n+1 bits are not all equal.
  - Rotates, pass-through and n=0: err=0.
- When not defined, err is tied to 0 and the check logic is absent.

Decomposition:
- Package barrel_shift_pkg:
  - Mode constants MODE_LSL=3'b000, MODE_LSR, MODE_ASL, MODE_ASR, MODE_ROL, MODE_ROR.
  - State enum IDLE/SHIFT/DONE.
  - Function inverse_dir(mode) returning the direction and rotate flag.
- Sub-module unshift_step: combinational one-position shift, inputs WIDTH data, dir (0=left, 1=right) and rotate; zero fill when not rotating. Instantiated once in the datapath.

Test Plan:
- ROR inverse: mode=101, data_in=4'b1101, amt=1 -> data_out=4'b1011 (ROL by 1), lossy=0, out_valid 2 cycles after accept.
- LSL inverse: mode=000, data_in=4'b1100, amt=2 -> data_out=4'b0011, lossy=1, err=0; with UNSHIFT_CHECK_EN, data_in=4'b0111, amt=1 -> err=1.
- ASR inverse: mode=011, data_in=4'b1110, amt=2 -> data_out=4'b1000, lossy=1, err=0; data_in=4'b1010, amt=2 -> err=1 (check enabled).
- Pass-through: mode=110, data_in=4'b1010, amt=3 -> data_out=4'b1010, lossy=0, out_valid 1 cycle after accept.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, data_out and lossy stable, in_ready=0, second in_valid ignored; out_ready=1 -> IDLE, then the second request is accepted.
- Reset mid-op: ROL, amt=3, rst_n pulsed low during the 2nd SHIFT cycle -> immediate IDLE, data_out=0, out_valid=0, in_ready=1 after release.

Source files
------------

// File: rtl/barrel_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift_pkg
// Description : Shared mode encodings, FSM state type and inverse-operation
//               lookup for the barrel shifter / unshifter datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package barrel_shift_pkg;

    // Shift-mode encodings, identical to the forward barrel shifter
    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASL = 3'b010;
    localparam logic [2:0] MODE_ASR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ROR = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // dir: 0 = shift left, 1 = shift right; rot: wrap instead of zero fill
    typedef struct packed {
        logic dir;
        logic rot;
    } inv_op_t;

    // Map a forward mode to the single-step operation that undoes it
    function automatic inv_op_t inverse_dir(input logic [2:0] mode);
        inv_op_t op;
        op = '{dir: 1'b0, rot: 1'b0};
        case (mode)
            MODE_LSL, MODE_ASL: op = '{dir: 1'b1, rot: 1'b0};
            MODE_LSR, MODE_ASR: op = '{dir: 1'b0, rot: 1'b0};
            MODE_ROL:           op = '{dir: 1'b1, rot: 1'b1};
            MODE_ROR:           op = '{dir: 1'b0, rot: 1'b1};
            default:            op = '{dir: 1'b0, rot: 1'b0};
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unshift_step.sv
`default_nettype none
// ============================================================================
// Module      : unshift_step
// Description : Combinational one-position shift/rotate. Zero fill when not
//               rotating; dir 0 = left, 1 = right.
// Revision    : 1.0 - initial release
// ============================================================================
module unshift_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_dir,
    input  logic             i_rotate,
    output logic [WIDTH-1:0] o_data
);

    logic w_fill_right;
    logic w_fill_left;

    // Bit entering from the top (right shift) or bottom (left shift)
    assign w_fill_right = i_rotate & i_data[0];
    assign w_fill_left  = i_rotate & i_data[WIDTH-1];

    assign o_data = i_dir ? {w_fill_right, i_data[WIDTH-1:1]}
                          : {i_data[WIDTH-2:0], w_fill_left};

endmodule
`default_nettype wire

// File: rtl/barrel_unshifter_seq.sv
`default_nettype none
// ============================================================================
// Module      : barrel_unshifter_seq
// Description : Sequential inverse of the 4-bit barrel shifter. Restores the
//               pre-shift word one bit position per cycle behind a
//               valid/ready handshake and flags lossy reconstructions.
//               Optional macro UNSHIFT_CHECK_EN enables the input
//               consistency check driving err.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_unshifter_seq
    import barrel_shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] shift_amt,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             lossy,
    output logic             err
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_work;
    logic [2:0]       r_mode;
    logic [AMT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data_out;
    logic             r_lossy;
    logic             r_err;

    logic             w_accept;
    logic             w_pass;
    logic             w_rotate_mode;
    logic [AMT_W-1:0] w_amt_eff;
    logic             w_lossy;
    logic             w_err;
    logic             w_last_step;
    inv_op_t          w_op;
    logic [WIDTH-1:0] w_step;

    assign w_accept      = in_valid && (r_state == IDLE);
    assign w_pass        = mode[2] & mode[1];
    assign w_rotate_mode = mode[2] & ~mode[1];
    // Pass-through modes never iterate regardless of the claimed amount
    assign w_amt_eff     = w_pass ? '0 : shift_amt;
    assign w_lossy       = ~mode[2] && (shift_amt != '0);
    assign w_last_step   = (r_cnt == AMT_W'(1));
    assign w_op          = inverse_dir(r_mode);

`ifdef UNSHIFT_CHECK_EN
    // Flag inputs whose bit pattern could not have come from the claimed shift
    always_comb begin
        w_err = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            case (mode)
                MODE_LSL, MODE_ASL:
                    if ((i < int'(shift_amt)) && data_in[i]) w_err = 1'b1;
                MODE_LSR:
                    if ((i >= WIDTH - int'(shift_amt)) && data_in[i]) w_err = 1'b1;
                MODE_ASR:
                    if ((shift_amt != '0) && (i >= WIDTH - 1 - int'(shift_amt))
                        && (data_in[i] != data_in[WIDTH-1])) w_err = 1'b1;
                default: ;
            endcase
        end
    end
`else
    assign w_err = 1'b0;
`endif

    unshift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_data   (r_work),
        .i_dir    (w_op.dir),
        .i_rotate (w_op.rot),
        .o_data   (w_step)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic and handshake outputs
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = (w_amt_eff != '0) ? SHIFT : DONE;
            end
            SHIFT: begin
                if (w_last_step) w_next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: latch request, step the work word, publish on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work     <= '0;
            r_mode     <= '0;
            r_cnt      <= '0;
            r_data_out <= '0;
            r_lossy    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_work  <= data_in;
                        r_mode  <= mode;
                        r_cnt   <= w_amt_eff;
                        r_lossy <= w_lossy & ~w_rotate_mode;
                        r_err   <= w_err;
                        if (w_amt_eff == '0) r_data_out <= data_in;
                    end
                end
                SHIFT: begin
                    r_work <= w_step;
                    r_cnt  <= r_cnt - AMT_W'(1);
                    if (w_last_step) r_data_out <= w_step;
                end
                default: ;
            endcase
        end
    end

    assign data_out = r_data_out;
    assign lossy    = r_lossy;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_barrel_unshifter_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_unshifter_seq
// Description : Self-checking bench for barrel_unshifter_seq: directed vector
//               table, backpressure and mid-operation reset sequences, and
//               randomized requests against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_unshifter_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data_in;
    logic [1:0] shift_amt;
    logic [2:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] data_out;
    logic       lossy;
    logic       err;

    int n_pass;
    int n_total;

    barrel_unshifter_seq #(
        .WIDTH (4),
        .AMT_W (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shift_amt (shift_amt),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .lossy     (lossy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] m;
        logic [3:0] d;
        logic [1:0] a;
        logic [3:0] q;
        logic       l;
        logic       e_chk;
        int         lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Reference: restore the original word with plain integer arithmetic
    task automatic model(input logic [2:0] m, input logic [3:0] d, input logic [1:0] a,
                         output logic [3:0] q, output logic l, output logic e, output int lat);
        int n;
        int di;
        int r;
        n  = (m >= 3'd6) ? 0 : int'(a);
        di = int'(d);
        case (m)
            3'd0, 3'd2: r = di >> n;
            3'd1, 3'd3: r = (di << n) & 15;
            3'd4:       r = ((di >> n) | (di << (4 - n))) & 15;
            3'd5:       r = ((di << n) | (di >> (4 - n))) & 15;
            default:    r = di;
        endcase
        q   = r[3:0];
        l   = (m < 3'd4) && (n != 0);
        lat = n + 1;
        e   = 1'b0;
`ifdef UNSHIFT_CHECK_EN
        if (n != 0) begin
            case (m)
                3'd0, 3'd2: e = (di & ((1 << n) - 1)) != 0;
                3'd1:       e = (di >> (4 - n)) != 0;
                3'd3:       e = !(((di >> (3 - n)) == 0) || ((di >> (3 - n)) == ((1 << (n + 1)) - 1)));
                default:    e = 1'b0;
            endcase
        end
`endif
    endtask

    // One request; hold>0 keeps out_ready low that many cycles in DONE.
    // poke drives a second (ignored) request while the block is busy.
    task automatic txn(input string nm, input logic [2:0] m, input logic [3:0] d,
                       input logic [1:0] a, input int hold, input bit poke,
                       input logic [3:0] eq, input logic el, input logic ee, input int elat);
        int lat;
        @(negedge clk);
        check({nm, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        mode      = m;
        data_in   = d;
        shift_amt = a;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        data_in   = 4'($urandom);
        mode      = 3'($urandom);
        shift_amt = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({nm, " latency"}, 32'(lat), 32'(elat));
        check({nm, " data_out"}, 32'(data_out), 32'(eq));
        check({nm, " lossy"}, 32'(lossy), 32'(el));
        check({nm, " err"}, 32'(err), 32'(ee));
        if (poke) begin
            in_valid  = 1'b1;
            mode      = 3'b110;
            data_in   = 4'b0110;
            shift_amt = 2'd0;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({nm, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({nm, " hold data_out"}, 32'(data_out), 32'(eq));
            check({nm, " hold lossy"}, 32'(lossy), 32'(el));
            check({nm, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    logic [3:0] rq;
    logic       rl;
    logic       re;
    int         rlat;
    logic [2:0] rm;
    logic [3:0] rd;
    logic [1:0] ra;

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = '0;
        shift_amt = '0;
        mode      = '0;
        out_ready = 1'b1;

        vecs[0] = '{3'b101, 4'b1101, 2'd1, 4'b1011, 1'b0, 1'b0, 2};
        vecs[1] = '{3'b000, 4'b1100, 2'd2, 4'b0011, 1'b1, 1'b0, 3};
        vecs[2] = '{3'b000, 4'b0111, 2'd1, 4'b0011, 1'b1, 1'b1, 2};
        vecs[3] = '{3'b011, 4'b1110, 2'd2, 4'b1000, 1'b1, 1'b0, 3};
        vecs[4] = '{3'b011, 4'b1010, 2'd2, 4'b1000, 1'b1, 1'b1, 3};
        vecs[5] = '{3'b110, 4'b1010, 2'd3, 4'b1010, 1'b0, 1'b0, 1};
        vecs[6] = '{3'b010, 4'b1000, 2'd3, 4'b0001, 1'b1, 1'b0, 4};
        vecs[7] = '{3'b001, 4'b0011, 2'd3, 4'b1000, 1'b1, 1'b1, 4};
        vecs[8] = '{3'b100, 4'b0110, 2'd0, 4'b0110, 1'b0, 1'b0, 1};

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset data_out", 32'(data_out), 32'd0);
        check("reset lossy", 32'(lossy), 32'd0);
        check("reset err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
`ifdef UNSHIFT_CHECK_EN
            txn($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].a, 0, 1'b0,
                vecs[i].q, vecs[i].l, vecs[i].e_chk, vecs[i].lat);
`else
            txn($sformatf("vec%0d", i), vecs[i].m, vecs[i].d, vecs[i].a, 0, 1'b0,
                vecs[i].q, vecs[i].l, 1'b0, vecs[i].lat);
`endif
        end

        // Backpressure with an ignored request while busy, then its acceptance
        txn("bp", 3'b000, 4'b1100, 2'd2, 5, 1'b1, 4'b0011, 1'b1, 1'b0, 3);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp second out_valid", 32'(out_valid), 32'd1);
        check("bp second data_out", 32'(data_out), 32'b0110);
        check("bp second lossy", 32'(lossy), 32'd0);
        @(posedge clk);
        #1;
        check("bp second drop", 32'(out_valid), 32'd0);

        // Reset pulsed during the second SHIFT cycle of a ROL amt=3 request
        @(negedge clk);
        in_valid  = 1'b1;
        mode      = 3'b100;
        data_in   = 4'b1001;
        shift_amt = 2'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst shift in_ready", 32'(in_ready), 32'd0);
        check("rst shift data_out held", 32'(data_out), 32'b0110);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst data_out", 32'(data_out), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst lossy", 32'(lossy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post rst out_valid", 32'(out_valid), 32'd0);
        check("post rst in_ready", 32'(in_ready), 32'd1);

        // Randomized requests against the reference model
        for (int k = 0; k < 60; k++) begin
            rm = 3'($urandom_range(0, 7));
            rd = 4'($urandom);
            ra = 2'($urandom);
            model(rm, rd, ra, rq, rl, re, rlat);
            txn($sformatf("rnd%0d", k), rm, rd, ra, int'($urandom_range(0, 2)), 1'b0,
                rq, rl, re, rlat);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
